// File: rtl/hex_disp_pkg.sv
// Shared segment constants, FSM state type and the ASCII-to-7-segment encoder
// used by asc_hex_writer. Segment vectors are [0:6] = a..g, active-low.
package hex_disp_pkg;

  localparam logic [0:6] SEG_BLANK = 7'b111_1111;
  localparam logic [0:6] SEG_PLUS  = 7'b111_1000;
  localparam logic [0:6] SEG_MINUS = 7'b111_1110;
  localparam logic [0:6] SEG_A     = 7'b000_1000;
  localparam logic [0:6] SEG_P     = 7'b001_1000;

  localparam logic [0:6] SEG_DIGIT [0:9] = '{
    7'b000_0001, 7'b100_1111, 7'b001_0010, 7'b000_0110, 7'b100_1100,
    7'b010_0100, 7'b010_0000, 7'b000_1111, 7'b000_0000, 7'b000_0100
  };

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  function automatic logic [0:6] asc2seg(input logic [7:0] c);
    logic [0:6] seg;
    case (c)
      8'h30:        seg = SEG_DIGIT[0];
      8'h31:        seg = SEG_DIGIT[1];
      8'h32:        seg = SEG_DIGIT[2];
      8'h33:        seg = SEG_DIGIT[3];
      8'h34:        seg = SEG_DIGIT[4];
      8'h35:        seg = SEG_DIGIT[5];
      8'h36:        seg = SEG_DIGIT[6];
      8'h37:        seg = SEG_DIGIT[7];
      8'h38:        seg = SEG_DIGIT[8];
      8'h39:        seg = SEG_DIGIT[9];
      8'h41, 8'h61: seg = SEG_A;
      8'h50, 8'h70: seg = SEG_P;
      8'h2B:        seg = SEG_PLUS;
      8'h2D:        seg = SEG_MINUS;
      8'h20:        seg = SEG_BLANK;
      default:      seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/asc2seg_enc.sv
// Combinational ASCII-to-segment encoder on the character write path.
module asc2seg_enc
  import hex_disp_pkg::*;
(
  input  logic [7:0] char_i,
  output logic [0:6] seg_o
);

  assign seg_o = asc2seg(char_i);

endmodule

// File: rtl/asc_hex_writer.sv
// Eight-digit ASCII 7-segment writer with a shadow buffer and commit/clear FSM.
// Optional blinking is enabled by defining ASC_HEX_BLINK_EN.
module asc_hex_writer
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 8
`ifdef ASC_HEX_BLINK_EN
  , parameter int BLINK_HALF_PERIOD = 25_000_000
`endif
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [7:0] char_data,
  input  logic       char_valid,
  output logic       char_ready,
  input  logic       char_mode,
  input  logic [2:0] char_addr,
  input  logic       commit,
  input  logic       clear,
  output logic       busy,
`ifdef ASC_HEX_BLINK_EN
  input  logic [7:0] blink_mask,
`endif
  output logic [0:6] HEX0,
  output logic [0:6] HEX1,
  output logic [0:6] HEX2,
  output logic [0:6] HEX3,
  output logic [0:6] HEX4,
  output logic [0:6] HEX5,
  output logic [0:6] HEX6,
  output logic [0:6] HEX7
);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       ready_q, ready_d;
  logic [0:6] shadow_q [NUM_DIGITS];
  logic [0:6] shadow_d [NUM_DIGITS];
  logic [0:6] disp_q   [NUM_DIGITS];
  logic [0:6] disp_d   [NUM_DIGITS];
  logic [0:6] hex_view [NUM_DIGITS];
  logic [0:6] enc_seg;
  logic       accept;

  asc2seg_enc u_enc (
    .char_i (char_data),
    .seg_o  (enc_seg)
  );

  assign accept = char_valid & ready_q & (state_q == ST_IDLE);

  // Next-state, shadow-buffer write and visible-copy logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    disp_d   = disp_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && char_mode) begin
          shadow_d[char_addr] = enc_seg;
        end else if (accept) begin
          for (int i = 1; i < NUM_DIGITS; i++) begin
            shadow_d[i] = shadow_q[i-1];
          end
          shadow_d[0] = enc_seg;
        end else begin
          shadow_d = shadow_q;
        end
        // clear takes priority; a simultaneous commit is dropped
        if (clear) begin
          state_d = ST_CLEAR;
          cnt_d   = 3'd0;
        end else if (commit) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        shadow_d[cnt_q] = SEG_BLANK;
        if (cnt_q == 3'd7) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_COMMIT: begin
        disp_d  = shadow_q;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // Control and buffer registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      ready_q <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        shadow_q[i] <= SEG_BLANK;
        disp_q[i]   <= SEG_BLANK;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
    end
  end

`ifdef ASC_HEX_BLINK_EN
  localparam int BW = $clog2(BLINK_HALF_PERIOD + 1);

  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          phase_q, phase_d;
  logic [0:6]    hex_q [NUM_DIGITS];
  logic [0:6]    hex_d [NUM_DIGITS];

  // Blink timebase (phase 1 = shown) and masked output image built from next-cycle values.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_HALF_PERIOD - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (blink_mask[i] && !phase_d) begin
        hex_d[i] = SEG_BLANK;
      end else begin
        hex_d[i] = disp_d[i];
      end
    end
  end

  // Blink and output registers.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hex_q[i] <= SEG_BLANK;
      end
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      hex_q       <= hex_d;
    end
  end

  assign hex_view = hex_q;
`else
  assign hex_view = disp_q;
`endif

  assign char_ready = ready_q;
  assign busy       = (state_q != ST_IDLE);
  assign HEX0 = hex_view[0];
  assign HEX1 = hex_view[1];
  assign HEX2 = hex_view[2];
  assign HEX3 = hex_view[3];
  assign HEX4 = hex_view[4];
  assign HEX5 = hex_view[5];
  assign HEX6 = hex_view[6];
  assign HEX7 = hex_view[7];

endmodule

// File: tb/tb_asc_hex_writer.sv
// Randomised self-checking bench for asc_hex_writer: a character-level model
// of shadow buffer and display is compared against decoded HEX outputs.
module tb_asc_hex_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] char_data = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       char_mode = 1'b0;
  logic [2:0] char_addr = 3'd0;
  logic       commit = 1'b0;
  logic       clear = 1'b0;
  logic       busy;
  logic [0:6] hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;

  int n_total = 0;
  int n_bad = 0;

  // Character-level reference model
  logic [7:0] m_shadow [8];
  logic [7:0] m_disp [8];
  int         m_busy_left;
  logic       m_is_clear;
  logic       m_ready;

  asc_hex_writer dut (
    .CLOCK_50   (clk),
    .RESET_N    (rst_n),
    .char_data  (char_data),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .char_mode  (char_mode),
    .char_addr  (char_addr),
    .commit     (commit),
    .clear      (clear),
    .busy       (busy),
`ifdef ASC_HEX_BLINK_EN
    .blink_mask (8'h00),
`endif
    .HEX0 (hex0), .HEX1 (hex1), .HEX2 (hex2), .HEX3 (hex3),
    .HEX4 (hex4), .HEX5 (hex5), .HEX6 (hex6), .HEX7 (hex7)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] seg2asc(input logic [0:6] s);
    case (s)
      7'b000_0001: return "0";
      7'b100_1111: return "1";
      7'b001_0010: return "2";
      7'b000_0110: return "3";
      7'b100_1100: return "4";
      7'b010_0100: return "5";
      7'b010_0000: return "6";
      7'b000_1111: return "7";
      7'b000_0000: return "8";
      7'b000_0100: return "9";
      7'b000_1000: return "A";
      7'b001_1000: return "P";
      7'b111_1000: return "+";
      7'b111_1110: return "-";
      7'b111_1111: return " ";
      default:     return "?";
    endcase
  endfunction

  function automatic logic [7:0] norm(input logic [7:0] c);
    if (c >= "0" && c <= "9") return c;
    case (c)
      "A", "a": return "A";
      "P", "p": return "P";
      "+":      return "+";
      "-":      return "-";
      default:  return " ";
    endcase
  endfunction

  function automatic logic [63:0] obs_disp();
    return {seg2asc(hex7), seg2asc(hex6), seg2asc(hex5), seg2asc(hex4),
            seg2asc(hex3), seg2asc(hex2), seg2asc(hex1), seg2asc(hex0)};
  endfunction

  function automatic logic [63:0] obs_raw();
    return {8'h00, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
  endfunction

  function automatic logic [63:0] exp_disp();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[i*8 +: 8] = m_disp[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_shadow[i] = " ";
      m_disp[i]   = " ";
    end
    m_busy_left = 0;
    m_is_clear  = 1'b0;
    m_ready     = 1'b0;
  endtask

  // Applies one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    if (m_busy_left == 0) begin
      if (char_valid && m_ready) begin
        if (char_mode) begin
          m_shadow[char_addr] = norm(char_data);
        end else begin
          for (int i = 7; i > 0; i--) m_shadow[i] = m_shadow[i-1];
          m_shadow[0] = norm(char_data);
        end
      end
      if (clear) begin
        m_busy_left = 8;
        m_is_clear  = 1'b1;
      end else if (commit) begin
        m_busy_left = 1;
        m_is_clear  = 1'b0;
      end
    end else begin
      if (m_is_clear) m_shadow[8 - m_busy_left] = " ";
      else m_disp = m_shadow;
      m_busy_left--;
    end
    m_ready = (m_busy_left == 0);
  endtask

  task automatic step(input logic v, input logic [7:0] c, input logic md,
                      input logic [2:0] a, input logic cl, input logic cm);
    char_valid = v;
    char_data  = c;
    char_mode  = md;
    char_addr  = a;
    clear      = cl;
    commit     = cm;
    @(posedge clk);
    model_edge();
    #1;
    char_valid = 1'b0;
    clear      = 1'b0;
    commit     = 1'b0;
    check_val("ready", {63'd0, char_ready}, {63'd0, m_ready});
    check_val("busy", {63'd0, busy}, {63'd0, (m_busy_left != 0)});
    check_val("display", obs_disp(), exp_disp());
  endtask

  task automatic step_idle();
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic shift_str(input string s);
    for (int i = 0; i < s.len(); i++) step(1'b1, s[i], 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic do_commit();
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b1);
    step_idle();
  endtask

  initial begin
    int         busy_cnt;
    string      pool;
    logic [7:0] c;

    pool = "0123456789AaPp+- Zx#";
    model_reset();
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", {63'd0, char_ready}, 64'd0);
    check_val("rst_busy", {63'd0, busy}, 64'd0);
    check_val("rst_raw", obs_raw(), {8'h00, {8{7'b111_1111}}});
    @(negedge clk) rst_n = 1'b1;
    step_idle();
    check_val("ready_after_rel", {63'd0, char_ready}, 64'd1);

    shift_str("12-34-56");
    do_commit();
    check_val("plan_12-34-56", obs_disp(), "12-34-56");

    shift_str("7");
    do_commit();
    check_val("plan_drop_hex7", obs_disp(), "2-34-567");

    step(1'b1, "P", 1'b1, 3'd1, 1'b0, 1'b0);
    step(1'b1, "A", 1'b1, 3'd0, 1'b0, 1'b0);
    step_idle();
    check_val("addr_no_commit", obs_disp(), "2-34-567");
    do_commit();
    check_val("addr_hex1", {57'd0, hex1}, {57'd0, 7'b001_1000});
    check_val("addr_hex0", {57'd0, hex0}, {57'd0, 7'b000_1000});

    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1);
    busy_cnt = 0;
    for (int k = 0; k < 20 && busy; k++) begin
      busy_cnt++;
      step_idle();
    end
    check_val("clr_busy_len", 64'(busy_cnt), 64'd8);
    check_val("clr_hex_kept", obs_disp(), "2-34-5PA");
    do_commit();
    check_val("clr_all_blank", obs_raw(), {8'h00, {8{7'b111_1111}}});

    // character together with clear is written and then blanked
    shift_str("8765432");
    step(1'b1, "1", 1'b0, 3'd0, 1'b1, 1'b0);
    repeat (8) step_idle();
    do_commit();
    check_val("char_clear", obs_disp(), "        ");

    shift_str("87654321");
    do_commit();
    step(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
    repeat (3) step_idle();
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_val("midclr_raw", obs_raw(), {8'h00, {8{7'b111_1111}}});
    check_val("midclr_busy", {63'd0, busy}, 64'd0);
    check_val("midclr_ready", {63'd0, char_ready}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    step_idle();
    check_val("midclr_ready_rel", {63'd0, char_ready}, 64'd1);
    do_commit();
    check_val("midclr_no_copy", obs_disp(), "        ");

    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) c = 8'($urandom_range(0, 255));
      else c = pool[$urandom_range(0, 19)];
      step(1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7)), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 7) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
